sys_spi_master: RTL and testbench

- SPI master that drives the Tangcores MCU command protocol from the FPGA side. It issues command bytes 1–7 and their payloads to a slave `sys` block.
- Used for the on-FPGA ROM streamer and as the bench driver for `sys`.
- Accepts one command per handshake, serialises the command byte plus payload MSB-first in SPI mode 0, and optionally returns MISO bytes (for example the config string from command 1).

---
 rtl/sys_spi_master.sv | 211 +++++++++++++++++++++
 tb/tb_sys_spi_master.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_spi_master.sv
// SPI mode-0 master for the MCU command protocol: opcode byte plus cmd_len payload
// bytes, MSB first, payload from the tx stream or zero-filled with MISO bytes returned on rx.
module sys_spi_master #(
   parameter int CLK_DIV = 4,
   parameter int CS_GAP  = 8
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [7:0]  cmd_byte,
   input  logic [23:0] cmd_len,
   input  logic        cmd_rd,
   input  logic [7:0]  tx_data,
   input  logic        tx_valid,
   output logic        tx_ready,
   output logic [7:0]  rx_data,
   output logic        rx_valid,
   output logic        busy,
   output logic        done,
   output logic        sspi_cs,
   output logic        sspi_clk,
   output logic        sspi_mosi,
   input  logic        sspi_miso
);

   typedef enum logic [2:0] {IDLE, LOW, HIGH, FETCH, TAIL, GAP} state_t;

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
   localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  tx_sh_q, tx_sh_d;
   logic [7:0]  rx_sh_q, rx_sh_d;
   logic [23:0] rem_q, rem_d;
   logic        rd_q, rd_d;
   logic        op_q, op_d;
   logic        cs_q, cs_d;
   logic        sclk_q, sclk_d;
   logic        mosi_q, mosi_d;
   logic        tx_ready_q, tx_ready_d;
   logic        rx_valid_q, rx_valid_d;
   logic [7:0]  rx_data_q, rx_data_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        more;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_d      = bit_q;
      tx_sh_d    = tx_sh_q;
      rx_sh_d    = rx_sh_q;
      rem_d      = rem_q;
      rd_d       = rd_q;
      op_d       = op_q;
      cs_d       = cs_q;
      sclk_d     = sclk_q;
      mosi_d     = mosi_q;
      rx_data_d  = rx_data_q;
      busy_d     = busy_q;
      tx_ready_d = 1'b0;
      rx_valid_d = 1'b0;
      done_d     = 1'b0;
      more       = 1'b0;
      case (state_q)
         IDLE: begin
            // busy_q in IDLE marks the one cycle between accept and CS falling
            if (busy_q) begin
               cs_d    = 1'b0;
               sclk_d  = 1'b0;
               mosi_d  = tx_sh_q[7];
               bit_d   = 3'd0;
               cnt_d   = 8'd0;
               state_d = LOW;
            end else if (cmd_valid) begin
               tx_sh_d = cmd_byte;
               rem_d   = cmd_len;
               rd_d    = cmd_rd;
               op_d    = 1'b1;
               busy_d  = 1'b1;
            end
         end
         LOW: begin
            if (cnt_q == DIV_LAST) begin
               cnt_d   = 8'd0;
               sclk_d  = 1'b1;
               rx_sh_d = {rx_sh_q[6:0], sspi_miso};
               state_d = HIGH;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         HIGH: begin
            if (cnt_q == DIV_LAST) begin
               cnt_d  = 8'd0;
               sclk_d = 1'b0;
               if (bit_q != 3'd7) begin
                  bit_d   = bit_q + 3'd1;
                  tx_sh_d = {tx_sh_q[6:0], 1'b0};
                  mosi_d  = tx_sh_q[6];
                  state_d = LOW;
               end else begin
                  bit_d = 3'd0;
                  op_d  = 1'b0;
                  // the opcode byte does not consume length and its MISO byte is dropped
                  if (op_q) begin
                     more = (rem_q != 24'd0);
                  end else begin
                     more  = (rem_q > 24'd1);
                     rem_d = (rem_q != 24'd0) ? rem_q - 24'd1 : 24'd0;
                     if (rd_q) begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = rx_sh_q;
                     end
                  end
                  state_d = more ? FETCH : TAIL;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         FETCH: begin
            if (rd_q) begin
               tx_sh_d = 8'h00;
               mosi_d  = 1'b0;
               cnt_d   = 8'd0;
               state_d = LOW;
            end else if (tx_valid) begin
               tx_ready_d = 1'b1;
               tx_sh_d    = tx_data;
               mosi_d     = tx_data[7];
               cnt_d      = 8'd0;
               state_d    = LOW;
            end
         end
         TAIL: begin
            if (cnt_q == DIV_LAST) begin
               cnt_d   = 8'd0;
               cs_d    = 1'b1;
               mosi_d  = 1'b0;
               state_d = GAP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d   = 8'd0;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= IDLE;
         cnt_q      <= 8'd0;
         bit_q      <= 3'd0;
         tx_sh_q    <= 8'd0;
         rx_sh_q    <= 8'd0;
         rem_q      <= 24'd0;
         rd_q       <= 1'b0;
         op_q       <= 1'b0;
         cs_q       <= 1'b1;
         sclk_q     <= 1'b0;
         mosi_q     <= 1'b0;
         tx_ready_q <= 1'b0;
         rx_valid_q <= 1'b0;
         rx_data_q  <= 8'd0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         tx_sh_q    <= tx_sh_d;
         rx_sh_q    <= rx_sh_d;
         rem_q      <= rem_d;
         rd_q       <= rd_d;
         op_q       <= op_d;
         cs_q       <= cs_d;
         sclk_q     <= sclk_d;
         mosi_q     <= mosi_d;
         tx_ready_q <= tx_ready_d;
         rx_valid_q <= rx_valid_d;
         rx_data_q  <= rx_data_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign cmd_ready = (state_q == IDLE) && !busy_q;
   assign tx_ready  = tx_ready_q;
   assign rx_valid  = rx_valid_q;
   assign rx_data   = rx_data_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign sspi_cs   = cs_q;
   assign sspi_clk  = sclk_q;
   assign sspi_mosi = mosi_q;

endmodule

// File: tb/tb_sys_spi_master.sv
// Scoreboard bench for sys_spi_master: a slave model collects MOSI bytes and plays back
// MISO bytes, while monitors compare bytes, rx data, CS/SCLK timing and handshakes.
module tb_sys_spi_master;

   localparam int CLK_DIV = 4;
   localparam int CS_GAP  = 8;

   logic        clk;
   logic        resetn;
   logic        cmd_valid, cmd_ready, cmd_rd;
   logic [7:0]  cmd_byte;
   logic [23:0] cmd_len;
   logic [7:0]  tx_data, rx_data;
   logic        tx_valid, tx_ready, rx_valid, busy, done;
   logic        sspi_cs, sspi_clk, sspi_mosi, sspi_miso;

   logic        f_rstn, f_cmd_valid, f_cmd_ready, f_tx_ready, f_rx_valid, f_busy, f_done;
   logic [7:0]  f_rx_data;
   logic        f_cs, f_sclk, f_mosi;

   int n_checks = 0;
   int n_errors = 0;

   int exp_mosi[$];
   int exp_rx[$];
   int exp_cs[$];
   int exp_exact[$];
   int exp_ntx[$];
   int exp_nrx[$];

   logic [7:0] miso_mem [0:63];
   logic [7:0] pay_mem  [0:63];
   logic [8:0] bitcnt;
   logic [7:0] mosi_sh;

   sys_spi_master #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) u_dut (
      .clk(clk), .resetn(resetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_byte(cmd_byte),
      .cmd_len(cmd_len), .cmd_rd(cmd_rd),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .done(done),
      .sspi_cs(sspi_cs), .sspi_clk(sspi_clk), .sspi_mosi(sspi_mosi), .sspi_miso(sspi_miso)
   );

   sys_spi_master #(.CLK_DIV(1), .CS_GAP(1)) u_fast (
      .clk(clk), .resetn(f_rstn),
      .cmd_valid(f_cmd_valid), .cmd_ready(f_cmd_ready), .cmd_byte(8'h06),
      .cmd_len(24'd0), .cmd_rd(1'b0),
      .tx_data(8'h00), .tx_valid(1'b0), .tx_ready(f_tx_ready),
      .rx_data(f_rx_data), .rx_valid(f_rx_valid), .busy(f_busy), .done(f_done),
      .sspi_cs(f_cs), .sspi_clk(f_sclk), .sspi_mosi(f_mosi), .sspi_miso(1'b0)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // slave model: MISO bit for the current SCLK count, MOSI sampled on rising SCLK
   assign sspi_miso = miso_mem[bitcnt[8:3]][3'd7 - bitcnt[2:0]];

   initial begin
      int e;
      bitcnt  = '0;
      mosi_sh = '0;
      forever begin
         @(posedge sspi_clk or negedge sspi_cs);
         if (sspi_clk) begin
            mosi_sh = {mosi_sh[6:0], sspi_mosi};
            if (bitcnt[2:0] == 3'd7) begin
               if (exp_mosi.size() == 0) chk("mosi unexpected byte", int'(mosi_sh), -1);
               else begin
                  e = exp_mosi.pop_front();
                  chk("mosi byte", int'(mosi_sh), e);
               end
            end
            bitcnt = bitcnt + 9'd1;
         end else begin
            bitcnt = '0;
         end
      end
   end

   initial begin
      int   cs_low, sclk_hi, gap, ntx, nrx, e, ex;
      logic prev_cs;
      prev_cs = 1'b1; cs_low = 0; sclk_hi = 0; gap = 0; ntx = 0; nrx = 0;
      forever begin
         @(negedge clk);
         if (!resetn) begin
            prev_cs = 1'b1; cs_low = 0; sclk_hi = 0; gap = 0; ntx = 0; nrx = 0;
         end else begin
            if (!sspi_cs) begin
               if (prev_cs) chk("busy at cs fall", int'(busy), 1);
               cs_low++;
            end else if (!prev_cs) begin
               if (exp_cs.size() == 0) chk("cs rise unexpected", cs_low, -1);
               else begin
                  e  = exp_cs.pop_front();
                  ex = exp_exact.pop_front();
                  if (ex != 0) chk("cs low cycles", cs_low, e);
                  else chk("cs low min cycles", (cs_low >= e) ? e : cs_low, e);
               end
               cs_low = 0;
               gap    = 0;
            end else begin
               gap++;
            end
            if (sspi_clk) sclk_hi++;
            else if (sclk_hi != 0) begin
               chk("sclk high width", sclk_hi, CLK_DIV);
               sclk_hi = 0;
            end
            if (sspi_cs && sspi_clk) chk("sclk high with cs high", 1, 0);
            if (tx_ready) ntx++;
            if (rx_valid) begin
               nrx++;
               if (exp_rx.size() == 0) chk("rx unexpected", int'(rx_data), -1);
               else begin
                  e = exp_rx.pop_front();
                  chk("rx byte", int'(rx_data), e);
               end
            end
            if (done) begin
               if (exp_ntx.size() == 0) chk("done unexpected", 1, 0);
               else begin
                  chk("tx_ready pulses", ntx, exp_ntx.pop_front());
                  chk("rx_valid pulses", nrx, exp_nrx.pop_front());
               end
               chk("done after cs gap", gap, CS_GAP);
               chk("busy at done", int'(busy), 0);
               chk("cmd_ready at done", int'(cmd_ready), 1);
               ntx = 0;
               nrx = 0;
            end
            prev_cs = sspi_cs;
         end
      end
   end

   task automatic issue(input logic [7:0] op, input int len, input logic rd, output bit ok);
      int t = 0;
      ok = 1'b1;
      while (!cmd_ready && t < 1000) begin
         @(negedge clk);
         t++;
      end
      if (!cmd_ready) begin
         chk("cmd_ready timeout", 0, 1);
         ok = 1'b0;
         return;
      end
      cmd_valid = 1'b1;
      cmd_byte  = op;
      cmd_len   = 24'(len);
      cmd_rd    = rd;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_byte  = 8'($urandom);
      cmd_len   = 24'($urandom);
   endtask

   task automatic feed(input int i, output bit ok);
      int t = 0;
      tx_valid = 1'b1;
      tx_data  = pay_mem[i];
      ok       = 1'b1;
      do begin
         @(negedge clk);
         t++;
      end while (!tx_ready && t < 5000);
      if (!tx_ready) begin
         chk("tx_ready timeout", 0, 1);
         ok = 1'b0;
      end
      tx_valid = 1'b0;
      tx_data  = 8'($urandom);
   endtask

   // reference: every byte is 16*CLK_DIV, each payload adds one fetch cycle, then CLK_DIV tail
   task automatic run_cmd(input logic [7:0] op, input int len, input logic rd,
                          input int stall_at, input int stall_len);
      bit ok;
      int t = 0;
      exp_mosi.push_back(int'(op));
      for (int i = 0; i < len; i++) begin
         exp_mosi.push_back(rd ? 0 : int'(pay_mem[i]));
         if (rd) exp_rx.push_back(int'(miso_mem[i + 1]));
      end
      exp_cs.push_back(16 * CLK_DIV * (len + 1) + len + CLK_DIV);
      exp_exact.push_back((rd || stall_at < 0) ? 1 : 0);
      exp_ntx.push_back(rd ? 0 : len);
      exp_nrx.push_back(rd ? len : 0);
      issue(op, len, rd, ok);
      if (!ok) return;
      if (!rd) begin
         for (int i = 0; i < len; i++) begin
            if (i == stall_at) repeat (stall_len) @(negedge clk);
            feed(i, ok);
            if (!ok) return;
         end
      end
      do begin
         @(negedge clk);
         t++;
      end while (!done && t < 20000);
      if (!done) chk("done timeout", 0, 1);
   endtask

   task automatic fill_miso();
      for (int i = 0; i < 64; i++) miso_mem[i] = 8'($urandom);
   endtask

   initial begin
      bit   ok;
      int   lowrun, highrun, ndone, len, sat;
      logic prev, seen_rise;
      resetn = 1'b0; f_rstn = 1'b0;
      cmd_valid = 1'b0; cmd_byte = '0; cmd_len = '0; cmd_rd = 1'b0;
      tx_valid = 1'b0; tx_data = '0; f_cmd_valid = 1'b0;
      fill_miso();
      repeat (3) @(negedge clk);
      chk("reset cs", int'(sspi_cs), 1);
      chk("reset sclk", int'(sspi_clk), 0);
      chk("reset mosi", int'(sspi_mosi), 0);
      chk("reset busy", int'(busy), 0);
      chk("reset done", int'(done), 0);
      chk("reset rx_valid", int'(rx_valid), 0);
      chk("reset tx_ready", int'(tx_ready), 0);
      chk("reset rx_data", int'(rx_data), 0);
      resetn = 1'b1; f_rstn = 1'b1;
      @(negedge clk);
      chk("cmd_ready after reset", int'(cmd_ready), 1);

      // CLK_DIV=1, CS_GAP=1 with cmd_valid held for two opcode-only commands
      f_cmd_valid = 1'b1;
      prev = 1'b1; seen_rise = 1'b0; lowrun = 0; highrun = 0; ndone = 0;
      for (int c = 0; c < 200 && ndone < 2; c++) begin
         @(negedge clk);
         if (!f_cs) begin
            if (prev && seen_rise) chk("fast cs gap", highrun, 3);
            lowrun++;
         end else begin
            if (!prev) begin
               chk("fast cs low", lowrun, 17);
               lowrun    = 0;
               highrun   = 1;
               seen_rise = 1'b1;
            end else if (seen_rise) highrun++;
         end
         if (f_done) ndone++;
         prev = f_cs;
      end
      f_cmd_valid = 1'b0;
      chk("fast done count", ndone, 2);

      pay_mem[0] = 8'h01;
      fill_miso();
      run_cmd(8'h03, 1, 1'b0, -1, 0);

      miso_mem[1] = 8'h54; miso_mem[2] = 8'h61; miso_mem[3] = 8'h6E; miso_mem[4] = 8'h67;
      run_cmd(8'h01, 4, 1'b1, -1, 0);

      pay_mem[0] = 8'h02; pay_mem[1] = 8'h00; pay_mem[2] = 8'h00;
      pay_mem[3] = 8'hAA; pay_mem[4] = 8'h55;
      fill_miso();
      run_cmd(8'h07, 5, 1'b0, 3, 16 * CLK_DIV + 20);

      run_cmd(8'h06, 0, 1'b0, -1, 0);

      // reset in the middle of the second payload byte
      pay_mem[0] = 8'hC3; pay_mem[1] = 8'h5A; pay_mem[2] = 8'h0F;
      exp_mosi.push_back(8'h07);
      exp_mosi.push_back(8'hC3);
      issue(8'h07, 3, 1'b0, ok);
      if (ok) feed(0, ok);
      if (ok) feed(1, ok);
      repeat (10) @(negedge clk);
      @(posedge clk);
      #2 resetn = 1'b0;
      #1;
      chk("midreset cs", int'(sspi_cs), 1);
      chk("midreset sclk", int'(sspi_clk), 0);
      chk("midreset mosi", int'(sspi_mosi), 0);
      chk("midreset busy", int'(busy), 0);
      chk("midreset rx_data", int'(rx_data), 0);
      repeat (2) @(negedge clk);
      chk("leftover mosi before resume", exp_mosi.size(), 0);
      exp_mosi.delete();
      resetn = 1'b1;
      @(negedge clk);
      chk("cmd_ready after midreset", int'(cmd_ready), 1);
      fill_miso();
      run_cmd(8'h03, 2, 1'b1, -1, 0);

      for (int n = 0; n < 10; n++) begin
         len = $urandom_range(0, 4);
         for (int i = 0; i < 64; i++) pay_mem[i] = 8'($urandom);
         fill_miso();
         sat = (len > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(0, len - 1) : -1;
         run_cmd(8'($urandom), len, 1'($urandom_range(0, 1)), sat, $urandom_range(1, 120));
      end

      repeat (5) @(negedge clk);
      chk("leftover mosi", exp_mosi.size(), 0);
      chk("leftover rx", exp_rx.size(), 0);
      chk("leftover transactions", exp_ntx.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
